hex_rotate_sched: RTL

//   Scheduler for the 3-position 2-bit character rotation on HEX2..HEX0.

---
 rtl/hex_rotate_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hex_rotate_sched.sv
`default_nettype none
// ============================================================================
//  Module   : hex_rotate_sched
//  Purpose  : Generates the 2-bit select for the three-position character
//             rotation on HEX2..HEX0. It auto-rotates at a fixed period,
//             supports pause/resume, and single-steps from a button.
//  Ports    : CLOCK_50 - system clock (rising edge)
//             RESET    - asynchronous active-high reset
//             EN       - 1 = auto-rotate, 0 = pause
//             DIR      - 0 = forward 0->1->2, 1 = reverse 0->2->1
//             CLEAR    - synchronous return to IDLE with SEL=0
//             STEP     - asynchronous button level; a rising edge advances once
//             SEL      - rotation select (0,1,2)
//             TICK     - one-cycle pulse in the cycle SEL takes a new value
//             STATE    - 00 IDLE, 01 RUN, 10 HOLD
//  Revision : 1.0 - initial release
// ============================================================================
module hex_rotate_sched #(
    parameter int DIV   = 50_000_000,
    parameter int CNT_W = 26
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       EN,
    input  logic       DIR,
    input  logic       CLEAR,
    input  logic       STEP,
    output logic [1:0] SEL,
    output logic       TICK,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               step_s1_q, step_s2_q, step_s3_q;
    logic               w_step_edge;
    logic [1:0]         w_sel_next;

    // Position advance; the unreachable code 3 folds back to 0.
    function automatic logic [1:0] next_sel(input logic [1:0] s, input logic d);
        logic [1:0] r;
        case (s)
            2'd0:    r = d ? 2'd2 : 2'd1;
            2'd1:    r = d ? 2'd0 : 2'd2;
            2'd2:    r = d ? 2'd1 : 2'd0;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // s1/s2 form the synchroniser; s3 is the previous synchronised level, so
    // the advance lands on the third rising edge after STEP goes high.
    assign w_step_edge = step_s2_q & ~step_s3_q;
    assign w_sel_next  = next_sel(sel_q, DIR);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        if (CLEAR) begin
            state_d = ST_IDLE;
            sel_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_step_edge) begin
                        sel_d  = w_sel_next;
                        tick_d = 1'b1;
                    end
                    if (EN) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    // Step-button edges seen here are dropped on purpose.
                    if (!EN) begin
                        state_d = ST_HOLD;
                    end else if (cnt_q == C_TERM) begin
                        cnt_d  = '0;
                        sel_d  = w_sel_next;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
                ST_HOLD: begin
                    // Counter stays frozen so RUN resumes mid-period.
                    if (w_step_edge) begin
                        sel_d  = w_sel_next;
                        tick_d = 1'b1;
                    end
                    if (EN) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            sel_q     <= 2'd0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            step_s1_q <= 1'b0;
            step_s2_q <= 1'b0;
            step_s3_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            step_s1_q <= STEP;
            step_s2_q <= step_s1_q;
            step_s3_q <= step_s2_q;
        end
    end

    assign SEL   = sel_q;
    assign TICK  = tick_q;
    assign STATE = state_q;

endmodule
`default_nettype wire
